// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Shares one FIFO write port among N_REQ valid/ready requesters. A requester
// that starts a multi-beat packet keeps the port until it sends its last beat.
// Round-robin selection happens between packets. Selection is combinational,
// so a beat is written to the FIFO in the same cycle in which it is accepted.
module fifo_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_last,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                fifo_full,
    output logic                fifo_wen,
    output logic [DW-1:0]       fifo_wdata,
    output logic                busy,
    output logic [IDW-1:0]      owner
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         fsm;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] sel;
    logic           sel_valid;
    logic           xfer;
    int unsigned    idx;

    // Round-robin successor. An explicit compare keeps the wrap correct
    // when N_REQ is not a power of two.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        if (32'(i) == 32'(N_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Selection: the lock owner while LOCKED, otherwise the first valid
    // requester found scanning cyclically from rr_ptr.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        idx       = 0;
        if (fsm == LOCKED) begin
            sel       = owner_q;
            sel_valid = 1'b1;
        end else begin
            for (int unsigned k = 0; k < 32'(N_REQ); k++) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= 32'(N_REQ)) begin
                    idx = idx - 32'(N_REQ);
                end
                if (!sel_valid && req_valid[IDW'(idx)]) begin
                    sel       = IDW'(idx);
                    sel_valid = 1'b1;
                end
            end
        end
    end

    // Handshake and FIFO write. Reset forces everything quiet.
    // While LOCKED the owner is offered ready even without valid, so a
    // bubble from the owner holds the port instead of releasing it.
    always_comb begin
        req_ready  = '0;
        xfer       = 1'b0;
        fifo_wdata = '0;
        if (!rst && sel_valid) begin
            fifo_wdata = req_data[sel*DW +: DW];
            if (!fifo_full && (fsm == LOCKED || req_valid[sel])) begin
                req_ready[sel] = 1'b1;
            end
            xfer = req_valid[sel] && req_ready[sel];
        end
    end

    assign fifo_wen = xfer;
    assign busy     = (fsm == LOCKED);
    assign owner    = owner_q;

    // Packet-lock FSM with round-robin pointer. State advances only on an
    // accepted beat; rr_ptr moves past the requester whose packet ended.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            rr_ptr  <= '0;
            owner_q <= '0;
        end else if (xfer) begin
            case (fsm)
                IDLE: begin
                    owner_q <= sel;
                    if (req_last[sel]) begin
                        rr_ptr <= next_idx(sel);
                    end else begin
                        fsm <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (req_last[sel]) begin
                        fsm    <= IDLE;
                        rr_ptr <= next_idx(owner_q);
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed testbench for fifo_write_arbiter (N_REQ=4, DW=8).
// Each beat's data is {lane, beat#}, so the write stream identifies its source.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wen;
    logic [7:0]  fifo_wdata;
    logic        busy;
    logic [1:0]  owner;

    logic [7:0]  d [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Packet tracker for the interleave check
    logic        in_pkt = 1'b0;
    logic [3:0]  cur_lane = '0;

    always_comb req_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    fifo_write_arbiter #(.N_REQ(4), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .owner      (owner)
    );

    // Interleave monitor: sampled mid-cycle, when inputs and outputs are settled
    always @(negedge clk) begin
        if (rst) begin
            in_pkt = 1'b0;
        end else if (fifo_wen) begin
            n_checks++;
            if (fifo_wdata[7:4] > 4'd3) begin
                $display("FAIL interleave_lane got=%0d required<4", fifo_wdata[7:4]);
                n_fail++;
            end else begin
                if (in_pkt && fifo_wdata[7:4] !== cur_lane) begin
                    $display("FAIL interleave got_lane=%0d required_lane=%0d", fifo_wdata[7:4], cur_lane);
                    n_fail++;
                end
                cur_lane = fifo_wdata[7:4];
                in_pkt   = !req_last[fifo_wdata[5:4]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [3:0] beat);
        for (int i = 0; i < 4; i++) d[i] = {4'(i), beat};
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_last = 4'hF; fifo_full = 1'b0; set_data(4'h5);
        tick();
        #1;
        n_checks++; if (fifo_wen !== 1'b0)     begin $display("FAIL rst_wen got=%b required=0", fifo_wen); n_fail++; end
        n_checks++; if (req_ready !== 4'b0000) begin $display("FAIL rst_ready got=%b required=0000", req_ready); n_fail++; end
        n_checks++; if (fifo_wdata !== 8'h00)  begin $display("FAIL rst_wdata got=%h required=00", fifo_wdata); n_fail++; end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0)         begin $display("FAIL rst_busy got=%b required=0", busy); n_fail++; end
        n_checks++; if (owner !== 2'd0)        begin $display("FAIL rst_owner got=%0d required=0", owner); n_fail++; end
        n_checks++; if (req_ready !== 4'b0001) begin $display("FAIL rst_first_grant got=%b required=0001", req_ready); n_fail++; end
        n_checks++; if (fifo_wdata !== 8'h05)  begin $display("FAIL rst_first_wdata got=%h required=05", fifo_wdata); n_fail++; end
        tick();
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        do_reset();
        req_valid = 4'hF; req_last = 4'hF;
        for (int unsigned c = 0; c < 8; c++) begin
            set_data(4'(c));
            exp = {4'(c % 4), 4'(c)};
            #1;
            n_checks++; if (fifo_wen !== 1'b1)              begin $display("FAIL rr_wen c=%0d got=%b required=1", c, fifo_wen); n_fail++; end
            n_checks++; if (req_ready !== 4'(1 << (c % 4))) begin $display("FAIL rr_ready c=%0d got=%b required=%b", c, req_ready, 4'(1 << (c % 4))); n_fail++; end
            n_checks++; if (fifo_wdata !== exp)             begin $display("FAIL rr_wdata c=%0d got=%h required=%h", c, fifo_wdata, exp); n_fail++; end
            tick();
        end
        req_valid = '0;
        #1;
        n_checks++; if (owner !== 2'd3) begin $display("FAIL rr_owner got=%0d required=3", owner); n_fail++; end
    endtask

    task automatic test_packet_lock();
        do_reset();
        // single beat from req0 moves rr_ptr to 1
        req_valid = 4'b0001; req_last = 4'b0001; set_data(4'h0);
        tick();
        req_valid = 4'b0111; req_last = 4'b0000;
        for (int unsigned b = 1; b <= 3; b++) begin
            set_data(4'(b));
            if (b == 3) req_last = 4'b0010;
            #1;
            n_checks++; if (req_ready !== 4'b0010)            begin $display("FAIL lock_ready b=%0d got=%b required=0010", b, req_ready); n_fail++; end
            n_checks++; if (fifo_wdata !== {4'h1, 4'(b)})     begin $display("FAIL lock_wdata b=%0d got=%h required=%h", b, fifo_wdata, {4'h1, 4'(b)}); n_fail++; end
            n_checks++; if (busy !== (b != 1))                begin $display("FAIL lock_busy b=%0d got=%b required=%b", b, busy, (b != 1)); n_fail++; end
            tick();
        end
        req_valid = 4'b0101; req_last = 4'b0101; set_data(4'h4);
        #1;
        n_checks++; if (busy !== 1'b0)         begin $display("FAIL lock_after_busy got=%b required=0", busy); n_fail++; end
        n_checks++; if (req_ready !== 4'b0100) begin $display("FAIL lock_next_grant got=%b required=0100", req_ready); n_fail++; end
        n_checks++; if (fifo_wdata !== 8'h24)  begin $display("FAIL lock_next_wdata got=%h required=24", fifo_wdata); n_fail++; end
        tick();
        req_valid = '0;
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b1000; req_last = 4'b0000; set_data(4'h1);
        #1;
        n_checks++; if (fifo_wdata !== 8'h31) begin $display("FAIL stall_b1 got=%h required=31", fifo_wdata); n_fail++; end
        tick();
        req_valid = 4'b1001; set_data(4'h2); fifo_full = 1'b1;
        for (int unsigned c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (fifo_wen !== 1'b0)     begin $display("FAIL stall_wen c=%0d got=%b required=0", c, fifo_wen); n_fail++; end
            n_checks++; if (req_ready !== 4'b0000) begin $display("FAIL stall_ready c=%0d got=%b required=0000", c, req_ready); n_fail++; end
            n_checks++; if (owner !== 2'd3)        begin $display("FAIL stall_owner c=%0d got=%0d required=3", c, owner); n_fail++; end
            n_checks++; if (busy !== 1'b1)         begin $display("FAIL stall_busy c=%0d got=%b required=1", c, busy); n_fail++; end
            tick();
        end
        fifo_full = 1'b0;
        #1;
        n_checks++; if (fifo_wen !== 1'b1)     begin $display("FAIL stall_resume_wen got=%b required=1", fifo_wen); n_fail++; end
        n_checks++; if (req_ready !== 4'b1000) begin $display("FAIL stall_resume_ready got=%b required=1000", req_ready); n_fail++; end
        n_checks++; if (fifo_wdata !== 8'h32)  begin $display("FAIL stall_resume_wdata got=%h required=32", fifo_wdata); n_fail++; end
        tick();
        req_last = 4'b1000; set_data(4'h3);
        #1;
        n_checks++; if (fifo_wdata !== 8'h33)  begin $display("FAIL stall_b3 got=%h required=33", fifo_wdata); n_fail++; end
        tick();
        req_valid = 4'b0001; req_last = 4'b0001;
        #1;
        n_checks++; if (busy !== 1'b0)         begin $display("FAIL stall_end_busy got=%b required=0", busy); n_fail++; end
        n_checks++; if (req_ready !== 4'b0001) begin $display("FAIL stall_end_grant got=%b required=0001", req_ready); n_fail++; end
        tick();
        req_valid = '0;
    endtask

    task automatic test_owner_bubble();
        do_reset();
        req_valid = 4'b0001; req_last = 4'b0000; set_data(4'h1);
        tick();
        req_valid = 4'b0010; set_data(4'h7);
        for (int unsigned c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (fifo_wen !== 1'b0)     begin $display("FAIL bubble_wen c=%0d got=%b required=0", c, fifo_wen); n_fail++; end
            n_checks++; if (req_ready !== 4'b0001) begin $display("FAIL bubble_ready c=%0d got=%b required=0001", c, req_ready); n_fail++; end
            tick();
        end
        req_valid = 4'b0011; req_last = 4'b0001; set_data(4'h2);
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin $display("FAIL bubble_last_ready got=%b required=0001", req_ready); n_fail++; end
        n_checks++; if (fifo_wdata !== 8'h02)  begin $display("FAIL bubble_last_wdata got=%h required=02", fifo_wdata); n_fail++; end
        tick();
        req_valid = 4'b0010; req_last = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin $display("FAIL bubble_next_ready got=%b required=0010", req_ready); n_fail++; end
        n_checks++; if (fifo_wdata !== 8'h12)  begin $display("FAIL bubble_next_wdata got=%h required=12", fifo_wdata); n_fail++; end
        tick();
        req_valid = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req_valid = 4'b0001; req_last = 4'b0001; set_data(4'h0);
        tick();
        req_valid = 4'b0100; req_last = 4'b0000; set_data(4'h1);
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin $display("FAIL rmid_b1_ready got=%b required=0100", req_ready); n_fail++; end
        tick();
        rst = 1'b1; req_valid = 4'b0111; set_data(4'h2);
        #1;
        n_checks++; if (fifo_wen !== 1'b0)     begin $display("FAIL rmid_wen got=%b required=0", fifo_wen); n_fail++; end
        n_checks++; if (req_ready !== 4'b0000) begin $display("FAIL rmid_ready got=%b required=0000", req_ready); n_fail++; end
        tick();
        rst = 1'b0; req_last = 4'b0111; set_data(4'h3);
        #1;
        n_checks++; if (busy !== 1'b0)         begin $display("FAIL rmid_busy got=%b required=0", busy); n_fail++; end
        n_checks++; if (owner !== 2'd0)        begin $display("FAIL rmid_owner got=%0d required=0", owner); n_fail++; end
        n_checks++; if (req_ready !== 4'b0001) begin $display("FAIL rmid_grant got=%b required=0001", req_ready); n_fail++; end
        n_checks++; if (fifo_wdata !== 8'h03)  begin $display("FAIL rmid_wdata got=%h required=03", fifo_wdata); n_fail++; end
        tick();
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; set_data(4'h0);
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_full_stall();
        test_owner_bubble();
        test_reset_mid_packet();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
